// File: rtl/boot_loader_m.sv
// Framed byte-stream loader: hunts for sync, takes a big-endian address and length, writes the
// payload into RAM over the shared bus, then releases the CPU only if the 8-bit checksum matches.
module boot_loader_m #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_bus_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [7:0]            o_mem_wdata,
    output logic                  o_mem_we,
    output logic                  o_cpu_run,
    output logic                  o_done,
    output logic                  o_error
);

    typedef enum logic [3:0] {
        StIdle, StSync, StAddrH, StAddrL, StLenH, StLenL, StData, StCsum, StDone, StError
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_arm;
    logic [ADDR_WIDTH-1:0] w_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [7:0]            r_csum;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]            r_mem_wdata;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_arm    = i_start && (r_state inside {StIdle, StDone, StError});
    // Full length as it will be once the low byte lands this cycle.
    assign w_len    = r_cnt | ADDR_WIDTH'(i_in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle, StDone, StError: if (i_start) w_next = StSync;
            StSync:  if (w_accept && i_in_data == SYNC_BYTE) w_next = StAddrH;
            StAddrH: if (w_accept) w_next = StAddrL;
            StAddrL: if (w_accept) w_next = StLenH;
            StLenH:  if (w_accept) w_next = StLenL;
            StLenL:  if (w_accept) w_next = (w_len == '0) ? StCsum : StData;
            StData:  if (w_accept && r_cnt == ADDR_WIDTH'(1)) w_next = StCsum;
            StCsum:  if (w_accept) w_next = (i_in_data == r_csum) ? StDone : StError;
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        o_in_ready = 1'b0;
        o_bus_req  = 1'b0;
        o_done     = 1'b0;
        o_error    = 1'b0;
        o_cpu_run  = 1'b0;
        unique case (r_state)
            StSync, StAddrH, StAddrL, StLenH, StLenL, StData, StCsum: begin
                o_in_ready = 1'b1;
                o_bus_req  = 1'b1;
            end
            StDone: begin
                o_done    = 1'b1;
                o_cpu_run = 1'b1;
            end
            StError: o_error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_arm) r_csum <= '0;
            if (w_accept) begin
                unique case (r_state)
                    StAddrH: r_addr <= ADDR_WIDTH'({i_in_data, 8'h00});
                    StAddrL: r_addr <= r_addr | ADDR_WIDTH'(i_in_data);
                    StLenH:  r_cnt  <= ADDR_WIDTH'({i_in_data, 8'h00});
                    StLenL:  r_cnt  <= w_len;
                    StData: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= i_in_data;
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_csum      <= r_csum + i_in_data;
                        r_cnt       <= r_cnt - ADDR_WIDTH'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
